// File: rtl/led_sequencer_if.sv
// Bus interface shared by leaders and followers: one request per cycle,
// reads answered later through read_data/read_data_valid.
interface led_sequencer_if;
  logic [31:0] addr;
  logic        read_req;
  logic        write_req;
  logic [3:0]  byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport leader (
    output addr, read_req, write_req, byte_enable, write_data,
    input  read_data, read_data_valid
  );

  modport follower (
    input  addr, read_req, write_req, byte_enable, write_data,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: fetches pattern words from a ROM over the bus,
// writes each one to the LED peripheral and holds it for a fixed time
// before moving to the next word, wrapping after the last one.
module led_sequencer #(
  parameter logic [31:0] RomBase       = 32'h2000_0000,
  parameter logic [31:0] LedBase       = 32'h1000_0000,
  parameter int          Length        = 5,
  parameter int          HoldCycles    = 1000,
  parameter int          TimeoutCycles = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  led_sequencer_if.leader bus,
  output logic           busy,
  output logic           error,
  output logic [7:0]     index
);

  localparam int HoldW = $clog2(HoldCycles + 1);
  localparam int WaitW = $clog2(TimeoutCycles + 1);

  localparam logic [HoldW-1:0] HoldLast  = HoldW'(HoldCycles - 1);
  localparam logic [WaitW-1:0] WaitLast  = WaitW'(TimeoutCycles - 1);
  localparam logic [7:0]       IndexLast = 8'(Length - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_WAIT,
    WRITE,
    HOLD
  } state_t;

  state_t           state;
  logic [31:0]      data_reg;
  logic [HoldW-1:0] hold_count;
  logic [WaitW-1:0] wait_count;

  // Sequencer FSM: a valid response in the last wait cycle still wins over
  // the timeout, and a dropped enable only takes effect once the current word
  // has been written and held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      data_reg   <= '0;
      hold_count <= '0;
      wait_count <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= READ_REQ;
          end
        end

        READ_REQ: begin
          wait_count <= '0;
          state      <= READ_WAIT;
        end

        READ_WAIT: begin
          if (bus.read_data_valid) begin
            data_reg <= bus.read_data;
            state    <= WRITE;
          end else if (wait_count == WaitLast) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end

        WRITE: begin
          hold_count <= '0;
          state      <= HOLD;
        end

        HOLD: begin
          if (hold_count == HoldLast) begin
            index <= (index == IndexLast) ? 8'd0 : index + 8'd1;
            state <= enable ? READ_REQ : IDLE;
          end else begin
            hold_count <= hold_count + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs are pure decodes of the registered state so they drop to
  // zero the moment reset forces the state back to IDLE.
  always_comb begin
    bus.addr        = '0;
    bus.read_req    = 1'b0;
    bus.write_req   = 1'b0;
    bus.byte_enable = '0;
    bus.write_data  = '0;
    case (state)
      READ_REQ: begin
        bus.addr     = RomBase + {22'd0, index, 2'b00};
        bus.read_req = 1'b1;
      end
      WRITE: begin
        bus.addr        = LedBase;
        bus.byte_enable = 4'h1;
        bus.write_data  = data_reg;
        bus.write_req   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Anything other than IDLE counts as an active sequence.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a ROM follower with adjustable read
// latency plus bus monitors that log every read request and LED write.
module tb_led_sequencer;

  localparam logic [31:0] ROM_BASE = 32'h2000_0000;
  localparam logic [31:0] LED_BASE = 32'h1000_0000;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       busy;
  logic       error;
  logic [7:0] index;

  led_sequencer_if bus_if ();

  led_sequencer #(
    .RomBase      (ROM_BASE),
    .LedBase      (LED_BASE),
    .Length       (5),
    .HoldCycles   (4),
    .TimeoutCycles(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bus   (bus_if),
    .busy  (busy),
    .error (error),
    .index (index)
  );

  int vectorCount = 0;
  int miscompareCount = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pattern ROM contents.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    logic [31:0] w;
    w = (a - ROM_BASE) >> 2;
    case (w)
      32'd0:   romWord = 32'h1;
      32'd1:   romWord = 32'h2;
      32'd2:   romWord = 32'h4;
      32'd3:   romWord = 32'h8;
      32'd4:   romWord = 32'hF;
      default: romWord = 32'hDEAD_BEEF;
    endcase
  endfunction

  // ROM follower: answers a read latency cycles after the request is
  // accepted (latency 0 means never); it deliberately ignores reset so a
  // response can arrive late.
  int          latency = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        stray_valid = 1'b0;
  logic [31:0] stray_data = '0;

  always @(posedge clk) begin
    if (bus_if.read_req && latency > 0) begin
      pend_cnt  <= latency;
      pend_addr <= bus_if.addr;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  assign bus_if.read_data_valid = (pend_cnt == 1) || stray_valid;
  assign bus_if.read_data       = stray_valid ? stray_data : romWord(pend_addr);

  // Bus monitors: log accepted reads and writes with their cycle numbers.
  int          cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_be_q[$];
  int          wr_cyc_q[$];
  logic [31:0] rd_addr_q[$];
  logic [7:0]  rd_idx_q[$];
  int          rd_cyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.write_req) begin
      wr_addr_q.push_back(bus_if.addr);
      wr_data_q.push_back(bus_if.write_data);
      wr_be_q.push_back(bus_if.byte_enable);
      wr_cyc_q.push_back(cyc);
    end
    if (bus_if.read_req) begin
      rd_addr_q.push_back(bus_if.addr);
      rd_idx_q.push_back(index);
      rd_cyc_q.push_back(cyc);
    end
  end

  // Safety net in case the design wedges in a way no bounded wait catches.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rst);
    @(negedge clk);
    enable = en;
    reset  = rst;
  endtask

  task automatic clearQueues();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_be_q.delete();
    wr_cyc_q.delete();
    rd_addr_q.delete();
    rd_idx_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitReadIndex(input logic [7:0] idx, input string tag);
    int n = 0;
    while (!(bus_if.read_req && index == idx) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitWriteIndex(input logic [7:0] idx, input string tag);
    int n = 0;
    while (!(bus_if.write_req && index == idx) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitReadCount(input int count, input string tag);
    int n = 0;
    while (rd_cyc_q.size() < count && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int en_cyc;
    int rel_cyc;
    int edges;
    logic [31:0] exp_pattern [5];
    exp_pattern = '{32'h1, 32'h2, 32'h4, 32'h8, 32'hF};

    // Reset values while reset is held.
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_index", {24'd0, index}, 32'd0);
    checkOutput("rst_addr", bus_if.addr, 32'd0);
    checkOutput("rst_read_req", {31'd0, bus_if.read_req}, 32'd0);
    checkOutput("rst_write_req", {31'd0, bus_if.write_req}, 32'd0);
    checkOutput("rst_byte_enable", {28'd0, bus_if.byte_enable}, 32'd0);
    checkOutput("rst_write_data", bus_if.write_data, 32'd0);
    reset = 1'b0;

    // A response strobe while idle must not start anything.
    @(negedge clk);
    stray_valid = 1'b1;
    stray_data  = 32'h0000_00AA;
    repeat (2) @(negedge clk);
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_writes", wr_cyc_q.size(), 32'd0);
    stray_valid = 1'b0;

    // Continuous run of 11 words with a 1-cycle follower.
    clearQueues();
    @(negedge clk);
    en_cyc = cyc;
    enable = 1'b1;
    waitReadCount(11, "run_wait_reads");
    enable = 1'b0;
    waitIdle("run_wait_idle");
    checkOutput("run_first_read_cyc", rd_cyc_q[0], en_cyc + 1);
    checkOutput("run_first_write_cyc", wr_cyc_q[0], en_cyc + 3);
    checkOutput("run_second_read_cyc", rd_cyc_q[1], en_cyc + 8);
    checkOutput("run_write_count", wr_cyc_q.size(), 32'd11);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("run_wdata%0d", i), wr_data_q[i], exp_pattern[i % 5]);
      checkOutput($sformatf("run_be%0d", i), {28'd0, wr_be_q[i]}, 32'h1);
      if (i > 0)
        checkOutput($sformatf("run_spacing%0d", i), wr_cyc_q[i] - wr_cyc_q[i-1], 32'd7);
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("run_raddr%0d", i), rd_addr_q[i], ROM_BASE + 32'(4 * i));
    end
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("run_ridx%0d", i), {24'd0, rd_idx_q[i]}, 32'(i % 5));
      checkOutput($sformatf("run_waddr%0d", i), wr_addr_q[i], LED_BASE);
    end
    checkOutput("run_final_index", {24'd0, index}, 32'd1);
    checkOutput("run_final_busy", {31'd0, busy}, 32'd0);

    // Follower never answers: timeout after 16 silent wait cycles.
    resetDut();
    clearQueues();
    latency = 0;
    enable  = 1'b1;
    waitReadIndex(8'd0, "to_wait_read");
    enable = 1'b0;
    @(posedge clk);
    #1;
    edges = 0;
    while (!error && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("to_edges", edges, 32'd16);
    checkOutput("to_error", {31'd0, error}, 32'd1);
    checkOutput("to_busy", {31'd0, busy}, 32'd0);
    checkOutput("to_index", {24'd0, index}, 32'd0);
    checkOutput("to_writes", wr_cyc_q.size(), 32'd0);

    // Error is sticky, yet a new sequence still runs.
    @(negedge clk);
    clearQueues();
    latency = 1;
    enable  = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    waitIdle("sticky_wait_idle");
    checkOutput("sticky_error", {31'd0, error}, 32'd1);
    checkOutput("sticky_writes", wr_cyc_q.size(), 32'd1);
    checkOutput("sticky_wdata", wr_data_q[0], 32'h1);
    checkOutput("sticky_index", {24'd0, index}, 32'd1);

    // Response on the 16th wait cycle beats the timeout.
    resetDut();
    clearQueues();
    latency = 16;
    enable  = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    waitIdle("late_wait_idle");
    checkOutput("late_error", {31'd0, error}, 32'd0);
    checkOutput("late_writes", wr_cyc_q.size(), 32'd1);
    checkOutput("late_wdata", wr_data_q[0], 32'h1);
    checkOutput("late_gap", wr_cyc_q[0] - rd_cyc_q[0], 32'd17);
    checkOutput("late_index", {24'd0, index}, 32'd1);

    // Enable dropped while word 2 is being fetched.
    resetDut();
    clearQueues();
    latency = 3;
    enable  = 1'b1;
    waitReadIndex(8'd2, "drop_wait_read");
    @(negedge clk);
    enable = 1'b0;
    waitWriteIndex(8'd2, "drop_wait_write");
    @(posedge clk);
    #1;
    edges = 0;
    while (busy && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("drop_hold_edges", edges, 32'd4);
    checkOutput("drop_writes", wr_cyc_q.size(), 32'd3);
    checkOutput("drop_wdata", wr_data_q[2], 32'h4);
    checkOutput("drop_index", {24'd0, index}, 32'd3);
    checkOutput("drop_busy", {31'd0, busy}, 32'd0);

    // Reset pulsed in the middle of word 3's hold.
    resetDut();
    latency = 1;
    enable  = 1'b1;
    waitWriteIndex(8'd3, "rsthold_wait_write");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rsthold_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsthold_index", {24'd0, index}, 32'd0);
    checkOutput("rsthold_write_req", {31'd0, bus_if.write_req}, 32'd0);
    checkOutput("rsthold_read_req", {31'd0, bus_if.read_req}, 32'd0);
    checkOutput("rsthold_addr", bus_if.addr, 32'd0);
    clearQueues();
    @(negedge clk);
    rel_cyc = cyc;
    reset   = 1'b0;
    waitReadCount(1, "rsthold_wait_read");
    checkOutput("rsthold_raddr", rd_addr_q[0], ROM_BASE);
    checkOutput("rsthold_read_cyc", rd_cyc_q[0], rel_cyc + 1);
    enable = 1'b0;
    waitIdle("rsthold_wait_idle");

    // Reset during a pending read; the late response must be ignored.
    resetDut();
    clearQueues();
    latency = 3;
    enable  = 1'b1;
    waitReadIndex(8'd0, "stale_wait_read");
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stale_busy", {31'd0, busy}, 32'd0);
    checkOutput("stale_writes", wr_cyc_q.size(), 32'd0);
    checkOutput("stale_error", {31'd0, error}, 32'd0);
    latency = 1;
    enable  = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    waitIdle("stale_wait_idle");
    checkOutput("stale_wdata", wr_data_q[0], 32'h1);
    checkOutput("stale_index", {24'd0, index}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter RomBase, 32'h2000_0000, byte address of ROM word 0.
REQ-002 Parameter LedBase, 32'h1000_0000, LED peripheral write address.
REQ-003 Parameter Length, 5, number of ROM words in the pattern (1..256).
REQ-004 Parameter HoldCycles, 1000, cycles each pattern word is displayed (>=1).
REQ-005 Parameter TimeoutCycles, 16, maximum read-response wait in cycles (>=1).
REQ-006 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port enable  in  1  start/continue sequencing while high.
REQ-009 Port bus  leader modport of the codebase bus interface: addr[31:0], read_req, write_req, byte_enable[3:0], write_data[31:0] driven; read_data[31:0], read_data_valid sampled.
REQ-010 Port busy  out  1  high whenever the state is not IDLE.
REQ-011 Port error  out  1  sticky read-timeout flag.
REQ-012 Port index  out  8  ROM word currently being fetched or displayed.

Function
REQ-013 FSM states SHALL be IDLE, READ_REQ, READ_WAIT, WRITE, HOLD; bus outputs SHALL be combinational decodes of the registered state.
REQ-014 In any state other than READ_REQ and WRITE, all bus outputs SHALL be 0.
REQ-015 IDLE: enable=1 -> READ_REQ; otherwise stay.
REQ-016 READ_REQ (one cycle): addr=RomBase+{index,2'b00} (32-bit add, wrap ignored), read_req=1 -> READ_WAIT; wait counter cleared.
REQ-017 READ_WAIT: read_data_valid=1 -> capture read_data into the data register -> WRITE.
REQ-018 READ_WAIT: without valid, the wait counter increments; after TimeoutCycles consecutive cycles without valid, error<=1, index unchanged -> IDLE.
REQ-019 Valid arriving on the same cycle the timeout would fire SHALL win (data captured, no error).
REQ-020 read_data_valid outside READ_WAIT SHALL be ignored.
REQ-021 WRITE (one cycle): addr=LedBase, byte_enable=4'h1, write_data=captured word, write_req=1 -> HOLD; hold counter cleared; no write acknowledge expected.
REQ-022 HOLD: stay exactly HoldCycles cycles, then index<=(index==Length-1)?0:index+1, then -> READ_REQ if enable=1, else IDLE.
REQ-023 enable falling mid-sequence SHALL NOT abort; the current word completes its WRITE and HOLD before IDLE.
REQ-024 error SHALL remain 1 until reset; sequencing SHALL still restart from IDLE when enable=1.
REQ-025 With a 1-cycle-latency follower: enable sampled in IDLE at cycle t -> read_req at t+1, valid at t+2, write_req at t+3, next read_req at t+4+HoldCycles (period HoldCycles+3).

Reset
REQ-026 On reset assertion, immediately (asynchronously): state=IDLE, index=0, data register=0, both counters=0, error=0, busy=0, all bus outputs=0.
REQ-027 Reset mid-operation (any state) SHALL discard pending reads; a late read_data_valid after reset release SHALL be ignored.
REQ-028 After reset release, first action SHALL be a read of RomBase when enable=1.

Verification
REQ-029 ROM=[1,2,4,8,F], HoldCycles=4, enable held -> LED writes 1,2,4,8,F,1 at 7-cycle spacing, byte_enable=4'h1, addrs 0x2000_0000..0x2000_0010.
REQ-030 Length=5, run 11 words -> index sequence 0..4,0..4,0; no write to addresses other than LedBase.
REQ-031 Follower never asserts valid, TimeoutCycles=16 -> error=1 exactly 16 cycles after read_req, state IDLE, index 0, no write_req.
REQ-032 Valid on the 16th wait cycle -> no error, word written normally.
REQ-033 enable dropped during READ_WAIT of word 2 -> word 2 written, held HoldCycles, index=3, IDLE, busy=0.
REQ-034 reset pulsed during HOLD of word 3 -> outputs 0 same cycle, index=0; after release with enable=1 first read at 0x2000_0000.
